// File: rtl/rr_arbiter16_pkg.sv
// Shared types and sizing for the 16-way round-robin arbiter.
// Latency: n/a (declarations only); backpressure: n/a.
package rr_arbiter16_pkg;

    localparam int NREQ  = 16;
    localparam int IDXW  = 4;
    localparam int HCNTW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/decoder4.sv
// 4-to-16 binary to one-hot decoder, purely combinational.
// Latency: 0 cycles; backpressure: none.
module decoder4 (
    input  logic [3:0]  idx,
    output logic [15:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with a per-owner hold limit; 1 cycle request-to-grant.
// Backpressure: none; owner keeps the grant while requesting, up to MAX_HOLD cycles.
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam logic [HCNTW-1:0] HOLD_LAST = HCNTW'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [IDXW-1:0]    ptr_q, ptr_d;
    logic [IDXW-1:0]    gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [HCNTW-1:0]   hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;
    logic [NREQ-1:0]    gnt_onehot;

    // First set bit searching upward from p, wrapping modulo NREQ.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDXW-1:0] p);
        logic [IDXW-1:0] idx;
        logic            found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = p + IDXW'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_idx_d   = rr_pick(req, ptr_q);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST)) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 1'b1;
                    // Still requesting at release means the limit forced it out.
                    timeout_d   = req[gnt_idx_q];
                end else begin
                    hold_cnt_d  = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    decoder4 u_decoder4 (
        .idx    (gnt_idx_q),
        .onehot (gnt_onehot)
    );

    assign gnt       = gnt_onehot & {NREQ{gnt_valid_q}};
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 Parameter: MAX_HOLD, default 16, the maximum number of consecutive grant cycles per owner (legal 1..255).
REQ-002 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port: req, input, 16, request lines; bit i = requester i.
REQ-005 Port: gnt, output, 16, one-hot grant; all zero when no owner.
REQ-006 Port: gnt_idx, output, 4, binary index of current/last owner.
REQ-007 Port: gnt_valid, output, 1, high while a grant is held.
REQ-008 Port: timeout, output, 1, one-cycle pulse after a forced release.

Function
REQ-009 The FSM SHALL have two states: IDLE (no owner, arbitrating) and GRANT (owner held).
REQ-010 In IDLE, if req != 0 at an edge, the FSM SHALL register the winner into gnt_idx, set gnt_valid, clear hold_cnt, and enter GRANT.
- Latency: 1 cycle from request to grant.
REQ-011 The winner SHALL be the first set bit of req in the search order ptr, ptr+1, ..., ptr+15 (mod 16).
REQ-012 In IDLE with req == 0, all state SHALL be held.
REQ-013 gnt SHALL equal the 4-to-16 one-hot decode of gnt_idx, ANDed with gnt_valid.
- gnt is combinational from registers only; no path from req to gnt.
REQ-014 In GRANT, hold_cnt (8 bits) SHALL increment by 1 every cycle the grant is kept.
REQ-015 In GRANT, release SHALL occur at an edge where req[gnt_idx]==0 (voluntary) or hold_cnt==MAX_HOLD-1 (forced).
REQ-016 On release, the FSM SHALL:
- return to IDLE;
- clear gnt_valid;
- set ptr = gnt_idx+1 mod 16 (15 wraps to 0);
- keep gnt_idx unchanged.
REQ-017 There SHALL be exactly one IDLE cycle (gnt == 0) between consecutive grants, including re-grant to the same requester.
REQ-018 timeout SHALL be high for exactly the IDLE cycle following a forced release, and low otherwise.
REQ-019 If req[gnt_idx] drops at the same edge the hold limit is reached, the release SHALL count as voluntary (timeout stays low).
REQ-020 With MAX_HOLD=1, every grant SHALL last exactly one cycle; timeout pulses if the owner's req is still high.
REQ-021 Requests from non-owners during GRANT SHALL be ignored until the next IDLE cycle; req changes on the owner's own bit have no effect except as release.

Reset
REQ-022 While rst_n is low, asynchronously and regardless of state, the block SHALL set state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, hold_cnt=0, timeout=0, and hence gnt=0.
- This applies mid-grant.
REQ-023 After rst_n deasserts, the first arbitration SHALL start its search at index 0.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, GRANT), the constants NREQ=16 and IDXW=4, and the hold counter width of 8.
REQ-025 The one-hot grant SHALL be produced by instantiating the existing decoder4 module (4-bit in, 16-bit one-hot out) on gnt_idx.
- No second decoder is written inline.
REQ-026 The rotating priority search SHALL be a combinational function inside rr_arbiter16; no other sub-modules.

Verification
REQ-027 Reset, then req=16'h0001 held 3 cycles then dropped -> gnt=16'h0001, gnt_idx=0 for 3 cycles, then gnt=0 for 1 cycle, ptr=1, timeout=0.
REQ-028 req=16'hFFFF constant, MAX_HOLD=2 -> grants to 0,1,2,...,15,0 in order, each 2 cycles wide, separated by one idle cycle; timeout pulses after every grant.
REQ-029 After a grant to 15 and release, req=16'h8001 -> next grant is index 0 (wrap); the following grant, if 15 is still requesting, is index 15.
REQ-030 Owner 5 holding, its req drops on the same edge hold_cnt==MAX_HOLD-1 -> release with timeout=0.
REQ-031 rst_n pulsed low mid-grant to index 9 -> gnt=0, gnt_valid=0, gnt_idx=0 immediately (asynchronously); after release with req=16'h0202, the grant goes to index 1.
REQ-032 While owner 3 is held, raise req[2] and req[4] -> no grant change until release; then grant goes to 4 (ptr=4).
